wb_i2c_reg_slave: RTL and testbench
===================================

# wb_i2c_reg_slave

Wishbone slave register block that answers the testbench Wishbone master. It decodes the four I2C-controller registers (CSR, DPR, CMDR, FSMR), issues byte-level commands to a back-end I2C engine through a valid/ready handshake, and collects completion status. It raises a sticky interrupt on command completion. It sits between the Wishbone bus and the I2C bit/byte engine in the DUT-side model of the layered testbench.

## Interface
- ADDR_WIDTH, 2, Wishbone address width; only adr_i[1:0] is decoded.
- DATA_WIDTH, 8, Wishbone data width; registers are 8 bits and upper bits read as 0.
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous and active-low.
- cyc_i, stb_i, we_i  in  1 each  Wishbone cycle, strobe and write-enable.
- adr_i  in  ADDR_WIDTH  register address: 0 = CSR, 1 = DPR, 2 = CMDR, 3 = FSMR.
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  read data, valid while ack_o is high.
- ack_o  out  1  one-cycle transfer acknowledge.
- irq_o  out  1  sticky interrupt.
- cmd_valid_o  out  1  command request to the engine.
- cmd_ready_i  in  1  engine accepts the command.
- cmd_o  out  3  command code.
- tx_data_o  out  8  DPR value captured when the command is issued.
- rsp_valid_i  in  1  one-cycle completion pulse from the engine.
- rsp_done_i, rsp_nack_i, rsp_arb_i  in  1 each  completion flags.
- rx_data_i  in  8  read byte from the engine.
- bus_busy_i, bus_capt_i  in  1 each  bus status.
- bus_id_i  in  4  selected bus.
- fsm_state_i  in  8  engine state, reflected in FSMR.

## Operation
- **Reset values:**
  - Outputs: dat_o = 0, ack_o = 0, irq_o = 0, cmd_valid_o = 0, cmd_o = 0, tx_data_o = 0.
  - Registers: CSR.E = 0, CSR.IE = 0, DPR = 0x00, CMDR = 0x80 (DON = 1), busy = 0.
- **CSR layout:** [7] E (rw), [6] IE (rw), [5] BB = bus_busy_i (ro), [4] BC = bus_capt_i (ro), [3:0] bus_id_i (ro).
- **CMDR layout:** [7] DON, [6] NAK, [5] AL, [4] ERR, [3] reserved (always reads 0, write ignored), [2:0] CMD.
- **FSMR:** read-only, returns fsm_state_i; writes ignored.
- **Acknowledge:** when cyc_i & stb_i & !ack_o, ack_o = 1 on the next edge for exactly one cycle. dat_o is registered in the same cycle. A write takes effect on the edge that raises ack_o.
- **E = 0:**
  - DPR and CMDR writes are ignored.
  - DPR, CMDR, busy and irq_o are held at their reset values.
  - cmd_valid_o = 0.
- **Writing E from 1 to 0 mid-command:** aborts the command. busy is cleared, cmd_valid_o drops next cycle, and any later rsp_valid_i is ignored.
- **CMDR write with E = 1:**
  - busy = 1: set ERR, leave the command unchanged.
  - CMD = 3'b111 (reserved): CMDR becomes ERR = 1, DON = 0; irq_o is set if IE = 1.
  - Otherwise: clear DON, NAK, AL and ERR; latch CMD into cmd_o; latch DPR into tx_data_o; set busy; assert cmd_valid_o.
- **Command handshake:** cmd_valid_o stays high until a cycle with cmd_ready_i = 1, then drops the next cycle. cmd_o and tx_data_o are stable while cmd_valid_o = 1.
- **Completion:** rsp_valid_i while busy and the command has been accepted:
  - busy = 0; DON, NAK and AL take rsp_done_i, rsp_nack_i and rsp_arb_i.
  - For CMD 3'b010 or 3'b011 (read ACK / read NAK), DPR <= rx_data_i.
  - irq_o is set if IE = 1.
  - rsp_valid_i while not busy is ignored.
- **irq_o clearing:** clears on the ack edge of a CMDR read, on a write of IE = 0, or when E = 0. A set and a clear in the same cycle: set wins.
- **DPR write while busy:** accepted, but tx_data_o is unaffected. DPR write in the same cycle as a read completion: the completion wins.

## Timing
- Read and write latency: one cycle from sampling stb_i to ack_o. ack_o never asserts on two consecutive cycles.
- CMDR write acked at edge N: cmd_valid_o = 1 from edge N+1. Minimum from issue to possible completion: 2 cycles.
- rsp_valid_i at edge M: CMDR status and irq_o are visible at M+1. A CMDR read started at M+1 returns the new status.
- Reset has priority over every event, including an in-flight Wishbone transfer. ack_o = 0 on the edge after reset is sampled low.

## Test plan
- Reset, then read all four registers: CSR = {2'b00, BB, BC, bus_id_i}; DPR = 0x00; CMDR = 0x80; ack_o lasts exactly 1 cycle per read.
- Write CSR = 0xC0, DPR = 0xA5, CMDR = 0x01 (write); hold cmd_ready_i low for 3 cycles → cmd_valid_o high 4 cycles with cmd_o = 1 and tx_data_o = 0xA5. Then rsp_valid_i with done = 1 → irq_o = 1; CMDR reads 0x81; irq_o = 0 after that read.
- Issue CMD = 3'b010 (read ACK); completion with rx_data_i = 0x3C → DPR reads 0x3C, CMDR reads 0x82.
- Write CMDR during a busy command → ERR set, cmd_o unchanged. Write CMDR = 0x07 when idle → CMDR reads 0x17, irq_o = 1; CMDR bit 3 always reads 0.
- Write CSR = 0x00 mid-command → cmd_valid_o drops, CMDR = 0x80, irq_o = 0; a later rsp_valid_i changes nothing.
- Same-cycle completion and CMDR-read clear → irq_o stays 1. Reset asserted mid-transfer → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/wb_i2c_reg_slave.sv
// Wishbone register front-end for the I2C byte engine: CSR/DPR/CMDR/FSMR decode,
// command issue over a valid/ready handshake, and completion status with a sticky irq.
module wb_i2c_reg_slave #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  irq_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [2:0]            cmd_o,
    output logic [7:0]            tx_data_o,
    input  logic                  rsp_valid_i,
    input  logic                  rsp_done_i,
    input  logic                  rsp_nack_i,
    input  logic                  rsp_arb_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  bus_busy_i,
    input  logic                  bus_capt_i,
    input  logic [3:0]            bus_id_i,
    input  logic [7:0]            fsm_state_i
);

    localparam logic [1:0] A_CSR  = 2'd0;
    localparam logic [1:0] A_DPR  = 2'd1;
    localparam logic [1:0] A_CMDR = 2'd2;
    localparam logic [1:0] A_FSMR = 2'd3;

    // ISSUE is the one-cycle gap between the CMDR write and cmd_valid_o rising.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_REQ, S_WAIT} state_t;
    state_t state_q, state_d;

    logic       e_q, ie_q;
    logic [7:0] dpr_q;
    logic       don_q, nak_q, al_q, err_q;
    logic [2:0] cmd_f_q;

    logic [1:0] adr;
    logic [7:0] wdat;
    logic       req, wr, rd;
    logic       wr_csr, wr_dpr, wr_cmdr, rd_cmdr;
    logic       e_d, busy, cmdr_wr, issue, rsv, complete;
    logic       irq_set, irq_clr;
    logic [7:0] rd_byte;

    always_comb begin
        adr      = adr_i[1:0];
        wdat     = dat_i[7:0];
        req      = cyc_i & stb_i & ~ack_o;
        wr       = req & we_i;
        rd       = req & ~we_i;
        wr_csr   = wr & (adr == A_CSR);
        wr_dpr   = wr & (adr == A_DPR) & e_q;
        wr_cmdr  = wr & (adr == A_CMDR);
        rd_cmdr  = rd & (adr == A_CMDR);
        e_d      = wr_csr ? wdat[7] : e_q;
        busy     = (state_q != S_IDLE);
        cmdr_wr  = wr_cmdr & e_q;
        issue    = cmdr_wr & ~busy & (wdat[2:0] != 3'b111);
        rsv      = cmdr_wr & ~busy & (wdat[2:0] == 3'b111);
        // Clearing E in the same cycle aborts, so a coincident response is dropped.
        complete = rsp_valid_i & (state_q == S_WAIT) & e_d;
        irq_set  = ie_q & (complete | rsv);
        irq_clr  = rd_cmdr | (wr_csr & ~wdat[6]);
    end

    always_comb begin
        rd_byte = 8'h00;
        case (adr)
            A_CSR:  rd_byte = {e_q, ie_q, bus_busy_i, bus_capt_i, bus_id_i};
            A_DPR:  rd_byte = dpr_q;
            A_CMDR: rd_byte = {don_q, nak_q, al_q, err_q, 1'b0, cmd_f_q};
            A_FSMR: rd_byte = fsm_state_i;
            default: rd_byte = 8'h00;
        endcase
    end

    // Command FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Command FSM: next state
    always_comb begin
        state_d = state_q;
        if (!e_d) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (issue) state_d = S_ISSUE;
                S_ISSUE: state_d = S_REQ;
                S_REQ:   if (cmd_ready_i) state_d = S_WAIT;
                S_WAIT:  if (rsp_valid_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Command FSM: outputs
    always_comb begin
        cmd_valid_o = (state_q == S_REQ);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_o     <= 1'b0;
            dat_o     <= '0;
            irq_o     <= 1'b0;
            cmd_o     <= 3'd0;
            tx_data_o <= 8'h00;
            e_q       <= 1'b0;
            ie_q      <= 1'b0;
            dpr_q     <= 8'h00;
            don_q     <= 1'b1;
            nak_q     <= 1'b0;
            al_q      <= 1'b0;
            err_q     <= 1'b0;
            cmd_f_q   <= 3'd0;
        end else begin
            ack_o <= req;
            dat_o <= req ? DATA_WIDTH'(rd_byte) : '0;

            if (wr_csr) begin
                e_q  <= wdat[7];
                ie_q <= wdat[6];
            end

            if (issue) begin
                cmd_o     <= wdat[2:0];
                tx_data_o <= dpr_q;
            end

            if (!e_d) begin
                dpr_q   <= 8'h00;
                don_q   <= 1'b1;
                nak_q   <= 1'b0;
                al_q    <= 1'b0;
                err_q   <= 1'b0;
                cmd_f_q <= 3'd0;
                irq_o   <= 1'b0;
            end else begin
                // Read-byte completion beats a coincident DPR write.
                if (complete && (cmd_o[2:1] == 2'b01)) dpr_q <= rx_data_i;
                else if (wr_dpr)                       dpr_q <= wdat;

                if (issue) begin
                    {don_q, nak_q, al_q, err_q} <= 4'b0000;
                    cmd_f_q <= wdat[2:0];
                end else if (rsv) begin
                    {don_q, nak_q, al_q, err_q} <= 4'b0001;
                    cmd_f_q <= 3'b111;
                end else if (cmdr_wr && busy) begin
                    err_q <= 1'b1;
                end

                if (complete) begin
                    don_q <= rsp_done_i;
                    nak_q <= rsp_nack_i;
                    al_q  <= rsp_arb_i;
                end

                if (irq_set)      irq_o <= 1'b1;
                else if (irq_clr) irq_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_i2c_reg_slave.sv
// Directed bench for wb_i2c_reg_slave: register access, command issue/complete,
// error paths, abort via E, irq set/clear race and reset mid-transfer.
module tb_wb_i2c_reg_slave;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cyc_i, stb_i, we_i;
    logic [1:0] adr_i;
    logic [7:0] dat_i, dat_o;
    logic       ack_o, irq_o, cmd_valid_o, cmd_ready_i;
    logic [2:0] cmd_o;
    logic [7:0] tx_data_o;
    logic       rsp_valid_i, rsp_done_i, rsp_nack_i, rsp_arb_i;
    logic [7:0] rx_data_i;
    logic       bus_busy_i, bus_capt_i;
    logic [3:0] bus_id_i;
    logic [7:0] fsm_state_i;

    int checks = 0;
    int failures = 0;
    logic [7:0] tmp;

    always #5 clk_i = ~clk_i;

    wb_i2c_reg_slave #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
        .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_o(cmd_o), .tx_data_o(tx_data_o),
        .rsp_valid_i(rsp_valid_i), .rsp_done_i(rsp_done_i),
        .rsp_nack_i(rsp_nack_i), .rsp_arb_i(rsp_arb_i), .rx_data_i(rx_data_i),
        .bus_busy_i(bus_busy_i), .bus_capt_i(bus_capt_i), .bus_id_i(bus_id_i),
        .fsm_state_i(fsm_state_i)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] wd,
                           output logic [7:0] rdat);
        int n;
        n = 0;
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = wd;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ack_o && n < 8);
        if (!ack_o) chk("ack_timeout", 8'(ack_o), 8'h01);
        rdat = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] r;
        wb_xfer(1'b1, a, d, r);
    endtask

    task automatic wb_rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] r;
        wb_xfer(1'b0, a, 8'h00, r);
        chk(tag, r, exp);
    endtask

    // Engine accepts on the next edge, then responds one cycle later.
    task automatic run_rsp(input logic done, input logic [7:0] rx);
        @(negedge clk_i); cmd_ready_i = 1'b1;
        @(negedge clk_i); cmd_ready_i = 1'b0;
        rsp_valid_i = 1'b1; rsp_done_i = done; rx_data_i = rx;
        @(negedge clk_i);
        rsp_valid_i = 1'b0; rsp_done_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = 0; dat_i = 0;
        cmd_ready_i = 0; rsp_valid_i = 0; rsp_done_i = 0; rsp_nack_i = 0; rsp_arb_i = 0;
        rx_data_i = 0; bus_busy_i = 1; bus_capt_i = 0; bus_id_i = 4'hA; fsm_state_i = 8'h5D;
        repeat (3) @(negedge clk_i);
        chk("rst_ack", 8'(ack_o), 8'h00);
        chk("rst_irq", 8'(irq_o), 8'h00);
        chk("rst_valid", 8'(cmd_valid_o), 8'h00);
        chk("rst_cmd", 8'(cmd_o), 8'h00);
        chk("rst_tx", tx_data_o, 8'h00);
        chk("rst_dat", dat_o, 8'h00);
        rst_i = 1'b1;

        wb_rd_chk("csr_rst", 2'd0, 8'h2A);
        @(negedge clk_i);
        chk("ack_one_cycle", 8'(ack_o), 8'h00);
        wb_rd_chk("dpr_rst", 2'd1, 8'h00);
        wb_rd_chk("cmdr_rst", 2'd2, 8'h80);
        wb_rd_chk("fsmr", 2'd3, 8'h5D);
        wb_wr(2'd3, 8'hFF);
        wb_rd_chk("fsmr_ro", 2'd3, 8'h5D);

        // Write command with a stalled engine
        wb_wr(2'd0, 8'hC0);
        wb_rd_chk("csr_en", 2'd0, 8'hEA);
        wb_wr(2'd1, 8'hA5);
        wb_wr(2'd2, 8'h01);
        chk("valid_gap", 8'(cmd_valid_o), 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("valid_hold", 8'(cmd_valid_o), 8'h01);
            chk("cmd_hold", 8'(cmd_o), 8'h01);
            chk("tx_hold", tx_data_o, 8'hA5);
            if (i == 3) cmd_ready_i = 1'b1;
        end
        @(negedge clk_i);
        cmd_ready_i = 1'b0;
        chk("valid_drop", 8'(cmd_valid_o), 8'h00);
        rsp_valid_i = 1'b1; rsp_done_i = 1'b1;
        @(negedge clk_i);
        rsp_valid_i = 1'b0; rsp_done_i = 1'b0;
        chk("irq_done", 8'(irq_o), 8'h01);
        wb_rd_chk("cmdr_done", 2'd2, 8'h81);
        chk("irq_rd_clr", 8'(irq_o), 8'h00);

        // Read-ACK command returns data into DPR
        wb_wr(2'd2, 8'h02);
        run_rsp(1'b1, 8'h3C);
        wb_rd_chk("dpr_rx", 2'd1, 8'h3C);
        wb_rd_chk("cmdr_rx", 2'd2, 8'h82);

        // CMDR write while busy, then reserved command
        wb_wr(2'd2, 8'h01);
        wb_wr(2'd2, 8'h04);
        wb_rd_chk("cmdr_busy_err", 2'd2, 8'h11);
        chk("cmd_busy_keep", 8'(cmd_o), 8'h01);
        run_rsp(1'b1, 8'h00);
        wb_rd_chk("cmdr_err_done", 2'd2, 8'h91);
        wb_wr(2'd2, 8'h07);
        chk("irq_rsv", 8'(irq_o), 8'h01);
        wb_rd_chk("cmdr_rsv", 2'd2, 8'h17);
        chk("cmd_rsv_keep", 8'(cmd_o), 8'h01);
        wb_wr(2'd2, 8'h09);
        wb_rd_chk("cmdr_bit3", 2'd2, 8'h01);

        // Abort by clearing E
        chk("valid_pre_abort", 8'(cmd_valid_o), 8'h01);
        wb_wr(2'd0, 8'h00);
        chk("valid_abort", 8'(cmd_valid_o), 8'h00);
        wb_rd_chk("cmdr_abort", 2'd2, 8'h80);
        chk("irq_abort", 8'(irq_o), 8'h00);
        @(negedge clk_i); rsp_valid_i = 1'b1; rsp_done_i = 1'b1; rsp_nack_i = 1'b1;
        @(negedge clk_i); rsp_valid_i = 1'b0; rsp_done_i = 1'b0; rsp_nack_i = 1'b0;
        wb_rd_chk("cmdr_late_rsp", 2'd2, 8'h80);
        chk("irq_late_rsp", 8'(irq_o), 8'h00);
        wb_wr(2'd1, 8'h55);
        wb_rd_chk("dpr_e0", 2'd1, 8'h00);

        // Completion and CMDR-read clear on the same edge
        wb_wr(2'd0, 8'hC0);
        wb_wr(2'd1, 8'h6B);
        wb_wr(2'd2, 8'h01);
        @(negedge clk_i); cmd_ready_i = 1'b1;
        @(negedge clk_i); cmd_ready_i = 1'b0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd2;
        rsp_valid_i = 1'b1; rsp_done_i = 1'b1;
        @(negedge clk_i);
        chk("race_ack", 8'(ack_o), 8'h01);
        chk("race_dat", dat_o, 8'h01);
        chk("race_irq", 8'(irq_o), 8'h01);
        cyc_i = 1'b0; stb_i = 1'b0; rsp_valid_i = 1'b0; rsp_done_i = 1'b0;
        chk("tx_pre_rst", tx_data_o, 8'h6B);

        // Reset during a write transfer
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 2'd1; dat_i = 8'h77;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_ack", 8'(ack_o), 8'h00);
        chk("mid_rst_irq", 8'(irq_o), 8'h00);
        chk("mid_rst_cmd", 8'(cmd_o), 8'h00);
        chk("mid_rst_tx", tx_data_o, 8'h00);
        chk("mid_rst_dat", dat_o, 8'h00);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        rst_i = 1'b1;
        wb_rd_chk("dpr_after_rst", 2'd1, 8'h00);
        wb_rd_chk("csr_after_rst", 2'd0, 8'h2A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
